branch_resolver: RTL and testbench

- Sequential branch-decision unit that consumes the ID-stage comparator flags (zero = RS==RT, gzero = signed RS>0, lzero = signed RS<0) and turns them into a PC redirect for IF.
- Accepts one branch at a time through a valid/ready handshake.
- Waits for forwarded operands to become valid, then issues a one-cycle redirect with the target.
- Keeps saturating statistics counters and aborts on pipeline flush or operand timeout.

---
 rtl/branch_resolver.sv | 127 ++++++++++++
 tb/tb_branch_resolver.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - branch-decision unit turning ID comparator flags into an IF redirect
module branch_resolver #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_op,
    input  logic [31:0]      br_target,
    input  logic             opnd_ready,
    input  logic             zero,
    input  logic             gzero,
    input  logic             lzero,
    input  logic             flush,
    output logic             stall,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             resolved,
    output logic             illegal_op,
    output logic             timeout_err,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [7:0]       TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t      state;
    state_t      state_nx;
    logic [2:0]  op_q;
    logic [31:0] tgt_q;
    logic [7:0]  wait_cnt;
    logic        accept;
    logic        eval;
    logic        expire;
    logic        taken;

    assign accept = br_valid && br_ready && !flush;
    assign eval   = (state == WAIT) && opnd_ready && !flush;
    // Expiry fires on the TIMEOUT-th starved WAIT cycle, so the error pulse lands TIMEOUT cycles in.
    assign expire = (state == WAIT) && !opnd_ready && (wait_cnt == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (br_valid) state_nx = WAIT;
                WAIT: begin
                    if (opnd_ready)  state_nx = DONE;
                    else if (expire) state_nx = IDLE;
                end
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        br_ready = (state == IDLE);
        stall    = (state == WAIT) && !opnd_ready;
    end

    // gzero and lzero together are not screened; each op looks only at its own flag.
    always_comb begin
        taken = 1'b0;
        case (op_q)
            3'd0:    taken = zero;
            3'd1:    taken = !zero;
            3'd2:    taken = gzero;
            3'd3:    taken = !gzero;
            3'd4:    taken = lzero;
            3'd5:    taken = !lzero;
            3'd6:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q        <= '0;
            tgt_q       <= '0;
            wait_cnt    <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            resolved    <= 1'b0;
            illegal_op  <= 1'b0;
            timeout_err <= 1'b0;
            br_cnt      <= '0;
            taken_cnt   <= '0;
        end else begin
            redirect    <= 1'b0;
            resolved    <= 1'b0;
            illegal_op  <= 1'b0;
            timeout_err <= expire && !flush;
            if (accept) begin
                op_q     <= br_op;
                tgt_q    <= br_target;
                wait_cnt <= '0;
            end else if (state == WAIT && !opnd_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (eval) begin
                redirect    <= taken;
                redirect_pc <= tgt_q;
                resolved    <= 1'b1;
                illegal_op  <= (op_q == 3'd7);
                if (br_cnt != CNT_MAX) br_cnt <= br_cnt + CNT_W'(1);
                if (taken && taken_cnt != CNT_MAX) taken_cnt <= taken_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - randomized bench for branch_resolver against a transaction-level model
module tb_branch_resolver;

    localparam int TO   = 15;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          br_valid = 1'b0;
    logic          br_ready;
    logic [2:0]    br_op = '0;
    logic [31:0]   br_target = '0;
    logic          opnd_ready = 1'b0;
    logic          zero = 1'b0;
    logic          gzero = 1'b0;
    logic          lzero = 1'b0;
    logic          flush = 1'b0;
    logic          stall;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          resolved;
    logic          illegal_op;
    logic          timeout_err;
    logic [CW-1:0] br_cnt;
    logic [CW-1:0] taken_cnt;

    int checks = 0;
    int fails  = 0;
    bit chk_en = 1'b0;

    branch_resolver #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .br_valid(br_valid), .br_ready(br_ready),
        .br_op(br_op), .br_target(br_target), .opnd_ready(opnd_ready),
        .zero(zero), .gzero(gzero), .lzero(lzero), .flush(flush), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .resolved(resolved),
        .illegal_op(illegal_op), .timeout_err(timeout_err),
        .br_cnt(br_cnt), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: one outstanding branch, its age in WAIT, and the pulses it must produce.
    bit          m_wait = 0, m_done = 0;
    int          m_age = 0, m_op = 0;
    logic [31:0] m_tgt = '0;
    bit          e_redir = 0, e_res = 0, e_ill = 0, e_to = 0;
    logic [31:0] e_pc = '0;
    int          e_br = 0, e_tk = 0;

    function automatic bit taken_of(input int op, input bit z, input bit g, input bit l);
        case (op)
            0: return z;
            1: return !z;
            2: return g;
            3: return !g;
            4: return l;
            5: return !l;
            6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_wait = 0; m_done = 0; m_age = 0; m_op = 0; m_tgt = '0;
            e_redir = 0; e_res = 0; e_ill = 0; e_to = 0; e_pc = '0; e_br = 0; e_tk = 0;
        end else begin
            bit t;
            e_redir = 0; e_res = 0; e_ill = 0; e_to = 0;
            if (flush) begin
                m_wait = 0;
                m_done = 0;
            end else if (m_done) begin
                m_done = 0;
            end else if (m_wait) begin
                if (opnd_ready) begin
                    t = taken_of(m_op, zero, gzero, lzero);
                    e_redir = t;
                    e_pc    = m_tgt;
                    e_res   = 1;
                    e_ill   = (m_op == 7);
                    if (e_br < CMAX) e_br++;
                    if (t && e_tk < CMAX) e_tk++;
                    m_wait = 0;
                    m_done = 1;
                end else begin
                    m_age++;
                    if (m_age == TO) begin
                        e_to   = 1;
                        m_wait = 0;
                    end
                end
            end else if (br_valid) begin
                m_wait = 1;
                m_age  = 0;
                m_op   = int'(br_op);
                m_tgt  = br_target;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("br_ready", br_ready, !(m_wait || m_done));
            chk("stall", stall, m_wait && !opnd_ready);
            chk("redirect", redirect, e_redir);
            chk("redirect_pc", redirect_pc, e_pc);
            chk("resolved", resolved, e_res);
            chk("illegal_op", illegal_op, e_ill);
            chk("timeout_err", timeout_err, e_to);
            chk("br_cnt", br_cnt, e_br);
            chk("taken_cnt", taken_cnt, e_tk);
        end
    end

    // Accept a branch, starve it for w cycles, then resolve; returns in the DONE cycle.
    task automatic do_branch(input int op, input logic [31:0] tgt, input bit z, input bit g,
                             input bit l, input int w, output int stalls);
        br_valid = 1; br_op = 3'(op); br_target = tgt;
        zero = z; gzero = g; lzero = l; opnd_ready = 1;
        step();
        br_valid = 0;
        stalls = 0;
        for (int i = 0; i < w; i++) begin
            opnd_ready = 0;
            #1;
            if (stall) stalls++;
            step();
        end
        opnd_ready = 1;
        step();
    endtask

    initial begin
        int s, n, drought;
        bit seen;
        step();
        step();
        reset = 0;
        chk_en = 1;
        chk("reset br_cnt", br_cnt, 0);
        chk("reset redirect", redirect, 0);
        chk("reset br_ready", br_ready, 1);

        do_branch(0, 32'h0040_0100, 1, 0, 0, 0, s);
        chk("beq redirect", redirect, 1);
        chk("beq redirect_pc", redirect_pc, 32'h0040_0100);
        chk("beq resolved", resolved, 1);
        chk("beq br_cnt", br_cnt, 1);
        chk("beq taken_cnt", taken_cnt, 1);
        step();

        do_branch(1, 32'h100, 1, 0, 0, 0, s);
        chk("bne redirect", redirect, 0);
        chk("bne resolved", resolved, 1);
        step();
        do_branch(3, 32'h200, 0, 0, 0, 0, s);
        chk("blez redirect", redirect, 1);
        step();
        do_branch(5, 32'h300, 0, 0, 1, 0, s);
        chk("bgez redirect", redirect, 0);
        step();
        chk("mix br_cnt", br_cnt, 4);
        chk("mix taken_cnt", taken_cnt, 2);

        do_branch(2, 32'h400, 0, 1, 0, 3, s);
        chk("bgtz stall cycles", s, 3);
        chk("bgtz redirect", redirect, 1);
        step();

        br_valid = 1; br_op = 3'd2; opnd_ready = 0;
        step();
        br_valid = 0;
        n = 0; seen = 0;
        while (n < 40 && !seen) begin
            step();
            n++;
            if (timeout_err) seen = 1;
        end
        chk("timeout seen", seen, 1);
        chk("timeout cycles", n, 15);
        chk("timeout br_cnt", br_cnt, 5);
        chk("timeout taken_cnt", taken_cnt, 3);
        step();

        br_valid = 1; br_op = 3'd6;
        step();
        br_valid = 0; opnd_ready = 1; flush = 1;
        step();
        flush = 0;
        chk("flush br_ready", br_ready, 1);
        chk("flush redirect", redirect, 0);
        chk("flush br_cnt", br_cnt, 5);

        do_branch(7, 32'h500, 1, 1, 1, 0, s);
        chk("illegal resolved", resolved, 1);
        chk("illegal illegal_op", illegal_op, 1);
        chk("illegal redirect", redirect, 0);
        step();

        reset = 1;
        step();
        reset = 0;
        for (int i = 0; i < 17; i++) begin
            do_branch(6, 32'h1000 + 32'(i), 0, 0, 0, 0, s);
            step();
        end
        chk("sat br_cnt", br_cnt, 15);
        chk("sat taken_cnt", taken_cnt, 15);

        br_valid = 1; br_op = 3'd6;
        step();
        br_valid = 0; opnd_ready = 0;
        #2 reset = 1;
        #1;
        chk("areset redirect", redirect, 0);
        chk("areset br_cnt", br_cnt, 0);
        chk("areset redirect_pc", redirect_pc, 0);
        chk("areset br_ready", br_ready, 1);
        step();
        reset = 0;
        do_branch(6, 32'hdead_beef, 0, 0, 0, 0, s);
        chk("post-reset redirect", redirect, 1);
        chk("post-reset redirect_pc", redirect_pc, 32'hdead_beef);
        step();

        drought = 0;
        for (int i = 0; i < 3000; i++) begin
            br_valid  = 1'($urandom);
            br_op     = 3'($urandom);
            br_target = $urandom;
            zero      = 1'($urandom);
            gzero     = 1'($urandom);
            lzero     = 1'($urandom);
            flush     = ($urandom_range(0, 29) == 0);
            reset     = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 79) == 0) drought = $urandom_range(10, 20);
            if (drought > 0) begin
                opnd_ready = 0;
                drought--;
            end else begin
                opnd_ready = ($urandom_range(0, 2) != 0);
            end
            step();
        end
        reset = 0; flush = 0; br_valid = 0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
